// File: rtl/tawas_dmem.sv
// tawas_dmem: data-side memory stage behind the Tawas load/store unit.
//
// Serves the fixed-latency, no-stall data bus. Read data is returned on DIN
// one cycle after each request. The block holds:
//   - a byte-maskable word RAM of 2^ADDR_W 32-bit words;
//   - a 16-byte MMIO window: CYCLES, ERRCNT, ERRADDR, SCRATCH;
//   - a sticky tracker for unmapped accesses and RAM accesses during clear;
//   - a post-reset sequencer that zeroes the RAM one word per cycle.
//
// Ports:
//   CLK        clock
//   RST        synchronous reset, active-high
//   DADDR      word-aligned byte address; bits [1:0] are ignored for decode
//   DCS        request valid, at most one request per cycle
//   DWR        1 = write, 0 = read
//   DMASK      byte-lane write enables; ignored for reads
//   DOUT       write data, already lane-replicated
//   DIN        registered read data; 0 after any cycle without a good read
//   INIT_DONE  high once the RAM clear has finished
//   ERR        sticky error flag; cleared by a masked write to ERRCNT
//
// Optional build macro TAWAS_DMEM_CYCLE_CNT_EN:
//   When defined, CYCLES is a free-running 32-bit counter.
//   When undefined, no counter is built and CYCLES reads 0.
module tawas_dmem #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter logic [31:0] IO_BASE  = 32'hFFFF_F000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DADDR,
  input  logic        DCS,
  input  logic        DWR,
  input  logic [3:0]  DMASK,
  input  logic [31:0] DOUT,
  output logic [31:0] DIN,
  output logic        INIT_DONE,
  output logic        ERR
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE  = 1;
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;
  logic              clearing;

  // Region decode. IO takes precedence in case the two windows are
  // ever configured to overlap.
  logic              io_hit, ram_hit, unmapped;
  logic [ADDR_W-1:0] req_idx;
  logic [1:0]        io_sel;

  assign io_hit   = (DADDR[31:4] == IO_BASE[31:4]);
  assign ram_hit  = !io_hit && (DADDR[31:ADDR_W+2] == RAM_BASE[31:ADDR_W+2]);
  assign unmapped = !io_hit && !ram_hit;
  assign req_idx  = DADDR[ADDR_W+1:2];
  assign io_sel   = DADDR[3:2];

  logic err_event, ram_wr_ok, ram_rd_ok, io_wr, io_rd, errcnt_clr, scratch_we;

  // A RAM request while the clear is running is an error, even when it
  // targets the word currently being cleared.
  assign err_event  = DCS && (unmapped || (ram_hit && clearing));
  assign ram_wr_ok  = DCS && DWR && ram_hit && !clearing && !RST;
  assign ram_rd_ok  = DCS && !DWR && ram_hit && !clearing;
  assign io_wr      = DCS && DWR && io_hit;
  assign io_rd      = DCS && !DWR && io_hit;
  assign errcnt_clr = io_wr && (io_sel == 2'd1) && (|DMASK);
  assign scratch_we = io_wr && (io_sel == 2'd3);

  // ---------------- clear sequencer FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= S_CLEAR;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    case (state_reg)
      S_CLEAR: begin
        clr_idx_next = clr_idx_reg + IDX_ONE;
        if (clr_idx_reg == IDX_LAST) state_next = S_READY;
      end
      default: state_next = S_READY;
    endcase
  end

  always_comb begin
    clearing  = (state_reg == S_CLEAR);
    INIT_DONE = (state_reg == S_READY);
  end

  // ---------------- RAM: one byte-wide array per lane ----------------
  // The clear sequencer owns the write port while it runs; bus writes
  // cannot collide with it because they are rejected during clear.
  logic [31:0] ram_rd_word;
  logic [31:0] scratch_reg, scratch_next;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_reg;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [7:0]        wd;

    assign we = clearing || (ram_wr_ok && DMASK[gi]);
    assign wa = clearing ? clr_idx_reg : req_idx;
    assign wd = clearing ? 8'h00 : DOUT[8*gi +: 8];

    always_ff @(posedge CLK) begin
      if (we) mem[wa] <= wd;
      rd_reg <= mem[req_idx];
    end

    assign ram_rd_word[8*gi +: 8]  = rd_reg;
    assign scratch_next[8*gi +: 8] = (scratch_we && DMASK[gi]) ? DOUT[8*gi +: 8]
                                                               : scratch_reg[8*gi +: 8];
  end

  // ---------------- optional cycle counter ----------------
  logic [31:0] cycles;
`ifdef TAWAS_DMEM_CYCLE_CNT_EN
  logic [31:0] cycles_reg;
  always_ff @(posedge CLK) begin
    if (RST) cycles_reg <= '0;
    else     cycles_reg <= cycles_reg + 32'd1;
  end
  assign cycles = cycles_reg;
`else
  assign cycles = '0;
`endif

  // ---------------- MMIO registers, error tracking, read return ----------------
  logic [31:0] err_cnt_reg, err_addr_reg, io_rd_reg, io_rd_mux;
  logic        err_reg, sel_ram_reg;

  always_comb begin
    io_rd_mux = '0;
    case (io_sel)
      2'd0:    io_rd_mux = cycles;
      2'd1:    io_rd_mux = err_cnt_reg;
      2'd2:    io_rd_mux = err_addr_reg;
      default: io_rd_mux = scratch_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_ram_reg  <= 1'b0;
      io_rd_reg    <= '0;
      err_reg      <= 1'b0;
      err_cnt_reg  <= '0;
      err_addr_reg <= '0;
      scratch_reg  <= '0;
    end else begin
      sel_ram_reg <= ram_rd_ok;
      io_rd_reg   <= io_rd ? io_rd_mux : '0;
      scratch_reg <= scratch_next;
      // Clearing ERRCNT wins over a coincident error event.
      if (errcnt_clr) begin
        err_reg      <= 1'b0;
        err_cnt_reg  <= '0;
        err_addr_reg <= '0;
      end else if (err_event) begin
        err_reg      <= 1'b1;
        err_addr_reg <= DADDR;
        if (err_cnt_reg != 32'hFFFF_FFFF) err_cnt_reg <= err_cnt_reg + 32'd1;
      end
    end
  end

  // The RAM read register is not reset, so it is only exposed after a
  // legal RAM read; otherwise the IO return register (0 when idle) is used.
  assign DIN = sel_ram_reg ? ram_rd_word : io_rd_reg;
  assign ERR = err_reg;

endmodule

// File: tb/tb_tawas_dmem.sv
// Directed self-checking bench for tawas_dmem with ADDR_W = 4 (16 words).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, so a value checked after one step reflects the request
// issued in the previous cycle.
module tb_tawas_dmem;

  localparam logic [31:0] IO_CYCLES  = 32'hFFFF_F000;
  localparam logic [31:0] IO_ERRCNT  = 32'hFFFF_F004;
  localparam logic [31:0] IO_ERRADDR = 32'hFFFF_F008;
  localparam logic [31:0] IO_SCRATCH = 32'hFFFF_F00C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] daddr;
  logic        dcs;
  logic        dwr;
  logic [3:0]  dmask;
  logic [31:0] dout;
  logic [31:0] din;
  logic        init_done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  tawas_dmem #(.ADDR_W(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .DADDR     (daddr),
    .DCS       (dcs),
    .DWR       (dwr),
    .DMASK     (dmask),
    .DOUT      (dout),
    .DIN       (din),
    .INIT_DONE (init_done),
    .ERR       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [3:0] m,
                     input logic [31:0] d);
    daddr = a; dcs = 1'b1; dwr = w; dmask = m; dout = d;
  endtask

  task automatic idle();
    dcs = 1'b0; dwr = 1'b0; dmask = 4'h0; dout = '0; daddr = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  logic [31:0] c1, c2;

  initial begin
    rst = 1'b1;
    idle();
    step(); step(); step();
    chk("rst_din", din, 32'h0);
    chk("rst_init_done", {31'b0, init_done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);

    // Clear runs for exactly 16 cycles after reset release.
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("clr1_init_done_%0d", k), {31'b0, init_done}, (k == 16) ? 32'h1 : 32'h0);
    end

    // Every word reads 0 after the clear.
    for (int i = 0; i < 16; i++) begin
      req(i * 4, 1'b0, 4'hF, '0);
      step();
      chk($sformatf("zero_word_%0d", i), din, 32'h0);
    end
    idle();
    step();
    chk("idle_err", {31'b0, err}, 32'h0);

    // Byte-masked write merge.
    req(32'h10, 1'b1, 4'b1111, 32'hA1B2C3D4); step();
    req(32'h10, 1'b1, 4'b0100, 32'h5555_5555); step();
    req(32'h10, 1'b0, 4'b0000, '0); step();
    chk("mask_merge", din, 32'hA155C3D4);

    // Write then immediate read; DIN drops to 0 when no read follows.
    req(32'h20, 1'b1, 4'hF, 32'h1234_5678); step();
    req(32'h20, 1'b0, 4'hF, '0); step();
    chk("wr_rd_b2b", din, 32'h1234_5678);
    idle(); step();
    chk("din_idle_zero", din, 32'h0);

    // Unmapped read.
    req(32'h8000_0000, 1'b0, 4'hF, '0); step();
    chk("unmapped_din", din, 32'h0);
    chk("unmapped_err", {31'b0, err}, 32'h1);
    req(IO_ERRCNT, 1'b0, 4'hF, '0); step();
    chk("errcnt_1", din, 32'h1);
    req(IO_ERRADDR, 1'b0, 4'hF, '0); step();
    chk("erraddr", din, 32'h8000_0000);
    chk("err_still_set", {31'b0, err}, 32'h1);
    req(IO_ERRCNT, 1'b1, 4'b0001, 32'h0); step();
    chk("err_cleared", {31'b0, err}, 32'h0);
    req(IO_ERRCNT, 1'b0, 4'hF, '0); step();
    chk("errcnt_0", din, 32'h0);
    req(IO_ERRADDR, 1'b0, 4'hF, '0); step();
    chk("erraddr_0", din, 32'h0);

    // SCRATCH byte-masked write.
    req(IO_SCRATCH, 1'b1, 4'b0011, 32'hDEAD_BEEF); step();
    req(IO_SCRATCH, 1'b0, 4'hF, '0); step();
    chk("scratch", din, 32'h0000_BEEF);

    // CYCLES: two reads five cycles apart.
    req(IO_CYCLES, 1'b0, 4'hF, '0); step();
    c1 = din;
    idle();
    step(); step(); step(); step();
    req(IO_CYCLES, 1'b0, 4'hF, '0); step();
    c2 = din;
    idle();
`ifdef TAWAS_DMEM_CYCLE_CNT_EN
    chk("cycles_delta", c2 - c1, 32'd5);
`else
    chk("cycles_zero_a", c1, 32'h0);
    chk("cycles_zero_b", c2, 32'h0);
`endif

    // RAM write during CLEAR, then reset mid-clear.
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    chk("clr2_init_done", {31'b0, init_done}, 32'h0);
    req(32'h10, 1'b1, 4'hF, 32'hFFFF_FFFF); step();
    chk("clr_wr_err", {31'b0, err}, 32'h1);
    req(32'h10, 1'b0, 4'hF, '0); step();
    chk("clr_rd_din", din, 32'h0);
    req(IO_ERRCNT, 1'b0, 4'hF, '0); step();
    chk("clr_errcnt", din, 32'h2);
    idle();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_err", {31'b0, err}, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("clr3_init_done_%0d", k), {31'b0, init_done}, (k == 16) ? 32'h1 : 32'h0);
    end
    chk("after_clr_err", {31'b0, err}, 32'h0);
    req(32'h10, 1'b0, 4'hF, '0); step();
    chk("target_cleared", din, 32'h0);
    req(32'h20, 1'b0, 4'hF, '0); step();
    chk("word8_cleared", din, 32'h0);
    req(IO_ERRCNT, 1'b0, 4'hF, '0); step();
    chk("errcnt_after_rst", din, 32'h0);
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
